pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer for the single-cycle/multicycle CPU datapath.
//  Holds the current fetch address and selects the next one: sequential, PC-relative branch,
//  absolute jump or return. Includes a RAS_DEPTH-entry return-address stack for call/return.
//  Sits between control unit / branch logic and instruction memory address port.
// PARAMETERS
//  ADDR_W     32  address width in bits
//  OFF_W      16  signed branch offset width (instruction units)
//  INSN_BYTES 4   bytes per instruction (power of 2, >=1); sequential step
//  RESET_VEC  0   address loaded on reset (must be INSN_BYTES-aligned)
//  RAS_DEPTH  4   return-address stack entries (power of 2, >=2)
// PORTS
//  CLK_in       in   1       clock, rising edge
//  Start_en     in   1       asynchronous active-low reset (0 = reset, 1 = run)
//  Halt_en      in   1       1 = hold PC and RAS unchanged this cycle
//  Next_sel     in   2       00 seq, 01 branch, 10 jump, 11 return
//  Offset_in    in   OFF_W   signed branch offset in instructions
//  Target_in    in   ADDR_W  absolute jump target
//  Push_en      in   1       call: push PC+INSN_BYTES onto RAS
//  Address_out  out  ADDR_W  current PC (registered)
//  Seq_out      out  ADDR_W  PC+INSN_BYTES, combinational from Address_out
//  Ras_empty    out  1       RAS holds 0 entries
//  Ras_full     out  1       RAS holds RAS_DEPTH entries
//  Ras_err      out  1       registered 1-cycle pulse: pop-on-empty or push-on-full
// BEHAVIOUR
//  Reset (Start_en=0, async): Address_out=RESET_VEC, RAS count=0, Ras_empty=1, Ras_full=0,
//   Ras_err=0; RAS entry contents don't-care. Release takes effect on next rising edge.
//  Each rising edge with Start_en=1, Halt_en=0: Address_out <= next, where
//   seq    = PC + INSN_BYTES
//   branch = PC + INSN_BYTES + (sext(Offset_in) * INSN_BYTES)
//   jump   = Target_in with low log2(INSN_BYTES) bits forced 0
//   return = RAS top; if RAS empty -> seq, Ras_err=1 next cycle
//  All arithmetic mod 2^ADDR_W; wrap at top of address space is silent.
//  Latency: selected next address visible on Address_out 1 cycle after the edge; 0 comb path
//   from Next_sel/Target_in/Offset_in to Address_out.
//  RAS: circular buffer, top pointer + count (0..RAS_DEPTH).
//   Push only (Push_en=1, Next_sel!=11): write seq to top+1; count+1.
//   Push on full: overwrite oldest entry (pointer wraps), count stays RAS_DEPTH, Ras_err=1.
//   Pop only (Next_sel=11, Push_en=0): count-1 if nonempty.
//   Push+pop same cycle: PC <- old top; top entry replaced by seq; count unchanged;
//    if empty: PC <- seq, push proceeds normally, Ras_err=1.
//   Push_en combined with seq/branch/jump: PC follows Next_sel, push value is always seq.
//  Halt_en=1: PC, RAS, count hold; Push_en/Next_sel ignored; Ras_err=0 that cycle.
//  Ras_err is 1 only in the cycle after the offending edge; otherwise 0.
//  Ras_empty/Ras_full decoded from registered count, no glitch paths.
//  Reset asserted mid-operation: immediate return to reset values regardless of Halt_en.
// TESTING
//  Reset with defaults, release, 3 edges Next_sel=00 -> Address_out 0,4,8,12; Ras_empty=1.
//  PC=0x100, Next_sel=01, Offset_in=-2 -> 0x0FC; Offset_in=0x7FFF -> 0x100+4+0x1FFFC.
//  PC=0x20 Push_en+Next_sel=10 Target_in=0x403 -> PC=0x400, RAS top=0x24; Next_sel=11 -> PC=0x24, empty.
//  5 pushes at RAS_DEPTH=4 -> Ras_full=1, Ras_err pulse on 5th; 4 pops return last 4 pushes LIFO.
//  Next_sel=11 on empty RAS at PC=0x40 -> PC=0x44, Ras_err=1 for one cycle; Halt_en=1 -> PC frozen.
//  PC=0xFFFFFFFC Next_sel=00 -> 0x0; Start_en low mid-branch -> Address_out=RESET_VEC immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: registered fetch address with seq/branch/jump/return selection
// and a circular return-address stack that overwrites its oldest entry when full.
module pc_sequencer #(
  parameter int ADDR_W     = 32,
  parameter int OFF_W      = 16,
  parameter int INSN_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int RAS_DEPTH  = 4
) (
  input  logic              CLK_in,
  input  logic              Start_en,
  input  logic              Halt_en,
  input  logic [1:0]        Next_sel,
  input  logic [OFF_W-1:0]  Offset_in,
  input  logic [ADDR_W-1:0] Target_in,
  input  logic              Push_en,
  output logic [ADDR_W-1:0] Address_out,
  output logic [ADDR_W-1:0] Seq_out,
  output logic              Ras_empty,
  output logic              Ras_full,
  output logic              Ras_err
);

  localparam int SH = $clog2(INSN_BYTES);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  typedef enum logic [1:0] {SEL_SEQ = 2'b00, SEL_BR = 2'b01, SEL_JMP = 2'b10, SEL_RET = 2'b11} sel_e;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PW-1:0]     top_q, top_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic              ras_we;
  logic [PW-1:0]     ras_waddr;
  logic [ADDR_W-1:0] seq_addr, br_addr, jmp_addr, off_ext;
  logic              is_pop, is_push, empty, full;
  sel_e              sel;

  assign sel      = sel_e'(Next_sel);
  assign seq_addr = pc_q + ADDR_W'(INSN_BYTES);
  assign off_ext  = ADDR_W'($signed(Offset_in));
  assign br_addr  = seq_addr + (off_ext << SH);
  assign jmp_addr = Target_in & ~ADDR_W'(INSN_BYTES - 1);
  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CW'(RAS_DEPTH));
  assign is_pop   = (sel == SEL_RET);
  assign is_push  = Push_en;

  always_comb begin
    pc_d      = pc_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    ras_we    = 1'b0;
    ras_waddr = top_q;
    if (!Halt_en) begin
      case (sel)
        SEL_SEQ: pc_d = seq_addr;
        SEL_BR:  pc_d = br_addr;
        SEL_JMP: pc_d = jmp_addr;
        SEL_RET: pc_d = empty ? seq_addr : ras_q[top_q];
        default: pc_d = seq_addr;
      endcase
      if (is_push && is_pop && !empty) begin
        // Call-through-return: the popped slot is reused for the new return address.
        ras_we    = 1'b1;
        ras_waddr = top_q;
      end else if (is_push) begin
        ras_we    = 1'b1;
        ras_waddr = top_q + PW'(1);
        top_d     = top_q + PW'(1);
        if (full) err_d = 1'b1;
        else      cnt_d = cnt_q + CW'(1);
        if (is_pop) err_d = 1'b1;
      end else if (is_pop) begin
        if (empty) begin
          err_d = 1'b1;
        end else begin
          top_d = top_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK_in or negedge Start_en) begin
    if (!Start_en) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge CLK_in) begin
    if (ras_we) ras_q[ras_waddr] <= seq_addr;
  end

  assign Address_out = pc_q;
  assign Seq_out     = seq_addr;
  assign Ras_empty   = empty;
  assign Ras_full    = full;
  assign Ras_err     = err_q;

endmodule
